// File: rtl/fir_mul_sched_pkg.sv
// fir_sched_pkg: shared types and constants for the shared-multiplier FIR
// scheduler.
//   state_t   : scheduler FSM states (IDLE, MAC, DONE)
//   DATA_W    : sample / coefficient width
//   PROD_W    : multiplier product width
//   acc_width : minimum overflow-free accumulator width for a tap count
package fir_sched_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int acc_width(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mul_sched_if.sv
// fir_mul_sched_if: sample stream, result stream and shared-multiplier bus of
// the FIR scheduler.
//   x_valid/x_ready/x_data : input sample handshake
//   y_valid/y_ready/y_data : filtered result handshake, ovf saturation flag
//   mul_en/mul_a/mul_b     : operand issue to the external 8x8 multiplier
//   mul_p                  : product returned by the multiplier
// Modports: slave = the scheduler, master = its environment (sample source,
// result sink and multiplier).
interface fir_mul_sched_if #(
  parameter int ACC_W = 19
);
  import fir_sched_pkg::*;

  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] x_data;
  logic              y_valid;
  logic              y_ready;
  logic [ACC_W-1:0]  y_data;
  logic              ovf;
  logic              mul_en;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_p;

  modport master (
    output x_valid, x_data, y_ready, mul_p,
    input  x_ready, y_valid, y_data, ovf, mul_en, mul_a, mul_b
  );

  modport slave (
    input  x_valid, x_data, y_ready, mul_p,
    output x_ready, y_valid, y_data, ovf, mul_en, mul_a, mul_b
  );

endinterface

// File: rtl/fir_mul_sched_issue_pipe.sv
// fir_issue_pipe: LAT-deep shift register that tracks issue tags alongside
// the external multiplier's pipeline, so the scheduler knows which cycle's
// mul_p is a live product. LAT=0 is a straight pass-through.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   din      : tag entering with the issue
//   dout     : tag aligned with the returned product
module fir_issue_pipe #(
  parameter int LAT = 0,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stg [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else begin
          stg[0] <= din;
          for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
      end

      assign dout = stg[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/fir_mul_sched.sv
// fir_mul_sched: time-multiplexes one external 8x8 unsigned multiplier over
// all taps of an FIR filter. Holds the sample delay line and coefficients,
// issues one tap product per clock, accumulates the returned products and
// presents one sum per accepted sample.
//   clk, rst  : clock, synchronous active-high reset
//   cfg_we    : coefficient write strobe (honoured in IDLE/DONE only)
//   cfg_addr  : tap index (writes to index >= TAPS are dropped)
//   cfg_data  : coefficient value
//   bus       : fir_mul_sched_if.slave (sample, result and multiplier bus)
// Parameters: TAPS (2..32), MUL_LAT (0..3, multiplier latency), ACC_W.
// Build option: define FIR_SAT_EN to clamp y_data to 16'hFFFF and drive ovf;
// otherwise y_data is the full sum and ovf stays low.
//
// state | meaning
// IDLE  | x_ready high, waiting for a sample
// MAC   | issuing taps 0..TAPS-1 and accumulating returned products
// DONE  | result held on y_data until y_ready
module fir_mul_sched
  import fir_sched_pkg::*;
#(
  parameter int TAPS    = 8,
  parameter int MUL_LAT = 0,
  parameter int ACC_W   = acc_width(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  fir_mul_sched_if.slave    bus
);

  localparam int KW = $clog2(TAPS);

  state_t            state;
  logic [DATA_W-1:0] d    [TAPS];
  logic [DATA_W-1:0] coef [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  y_nxt;
  logic [ACC_W-1:0]  y_data_r;
  logic [KW-1:0]     k;
  logic [KW-1:0]     k_nxt;
  logic              x_ready_r;
  logic              y_valid_r;
  logic              ovf_r;
  logic              ovf_nxt;
  logic              mul_en_r;
  logic              mul_last_r;
  logic [DATA_W-1:0] mul_a_r;
  logic [DATA_W-1:0] mul_b_r;
  logic [1:0]        pipe_in;
  logic [1:0]        pipe_out;
  logic              prod_valid;
  logic              prod_last;
  logic              cfg_hit;
  logic [KW-1:0]     cfg_idx;

  assign cfg_idx = cfg_addr[KW-1:0];
  assign cfg_hit = cfg_we && (int'(cfg_addr) < TAPS) && (state != MAC);
  assign k_nxt   = k + KW'(1);
  assign acc_nxt = acc + ACC_W'(bus.mul_p);

`ifdef FIR_SAT_EN
  localparam logic [ACC_W-1:0] PROD_MAX = ACC_W'(17'h0FFFF);
  assign ovf_nxt = (acc_nxt > PROD_MAX);
  assign y_nxt   = ovf_nxt ? PROD_MAX : acc_nxt;
`else
  assign ovf_nxt = 1'b0;
  assign y_nxt   = acc_nxt;
`endif

  // Tag bit 1 marks the last tap so completion follows the product, not the
  // issue, whatever the multiplier latency.
  assign pipe_in    = {mul_last_r, mul_en_r};
  assign prod_valid = pipe_out[0];
  assign prod_last  = pipe_out[1];

  fir_issue_pipe #(
    .LAT (MUL_LAT),
    .W   (2)
  ) u_issue_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        d[i]    <= '0;
        coef[i] <= '0;
      end
      acc        <= '0;
      k          <= '0;
      x_ready_r  <= 1'b1;
      y_valid_r  <= 1'b0;
      y_data_r   <= '0;
      ovf_r      <= 1'b0;
      mul_en_r   <= 1'b0;
      mul_last_r <= 1'b0;
      mul_a_r    <= '0;
      mul_b_r    <= '0;
    end else begin
      if (cfg_hit) coef[cfg_idx] <= cfg_data;

      case (state)
        IDLE: begin
          if (bus.x_valid) begin
            d[0] <= bus.x_data;
            for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
            acc        <= '0;
            k          <= '0;
            x_ready_r  <= 1'b0;
            state      <= MAC;
            // Tap 0 issues straight from the accepting edge; forward a
            // same-edge write to coef[0] so the sum sees the new value.
            mul_en_r   <= 1'b1;
            mul_last_r <= 1'b0;
            mul_a_r    <= bus.x_data;
            mul_b_r    <= (cfg_hit && cfg_idx == '0) ? cfg_data : coef[0];
          end
        end

        MAC: begin
          if (mul_en_r) begin
            if (mul_last_r) begin
              mul_en_r   <= 1'b0;
              mul_last_r <= 1'b0;
              mul_a_r    <= '0;
              mul_b_r    <= '0;
            end else begin
              k          <= k_nxt;
              mul_a_r    <= d[k_nxt];
              mul_b_r    <= coef[k_nxt];
              mul_last_r <= (k_nxt == KW'(TAPS - 1));
            end
          end
          if (prod_valid) begin
            acc <= acc_nxt;
            if (prod_last) begin
              state     <= DONE;
              y_valid_r <= 1'b1;
              y_data_r  <= y_nxt;
              ovf_r     <= ovf_nxt;
            end
          end
        end

        DONE: begin
          if (bus.y_ready) begin
            y_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
            x_ready_r <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_ready = x_ready_r;
  assign bus.y_valid = y_valid_r;
  assign bus.y_data  = y_data_r;
  assign bus.ovf     = ovf_r;
  assign bus.mul_en  = mul_en_r;
  assign bus.mul_a   = mul_a_r;
  assign bus.mul_b   = mul_b_r;

endmodule
